// File: rtl/image_loader_pkg.sv
// -----------------------------------------------------------------------------
// image_loader_pkg
// Shared definitions for the MNIST frame receiver.
//   - Default frame geometry (NUM_PIXELS, ADDR_W).
//   - Default sync header bytes (SYNC0, SYNC1).
//   - Default inter-byte timeout (TIMEOUT_CYCLES).
//   - Receiver state enum.
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package image_loader_pkg;

  localparam int          NUM_PIXELS     = 784;
  localparam int          ADDR_W         = 10;
  localparam logic [7:0]  SYNC0          = 8'hAA;
  localparam logic [7:0]  SYNC1          = 8'h55;
  localparam int          TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_LOAD,
`ifdef IMAGE_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_PEND,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/image_loader_byte_gap_timer.sv
// -----------------------------------------------------------------------------
// byte_gap_timer
// Clearable saturating cycle counter. Counts up every cycle that clear is low
// and sticks at TIMEOUT_CYCLES; expired is high while the count sits there.
// Ports:
//   clk      in  : clock, rising edge
//   rst_n    in  : asynchronous active-low reset
//   clear    in  : synchronous clear of the count
//   expired  out : count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count_reg;

  assign expired = (count_reg == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/image_loader.sv
// -----------------------------------------------------------------------------
// image_loader
// Receives a byte stream, finds the SYNC0/SYNC1 header, writes NUM_PIXELS
// pixel bytes to sequential RAM addresses and holds the finished image until
// the inference controller releases it with image_consume.
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN -- when defined, a trailing
// modulo-256 sum byte follows the pixels and is verified before handoff.
// Ports:
//   clk, rst_n                 : clock / asynchronous active-low reset
//   rx_data[7:0], rx_valid     : incoming byte strobe
//   ram_wr_addr, ram_wr_data,
//   ram_wr_en                  : RAM synchronous write port
//   image_valid                : RAM holds a complete frame (level)
//   image_consume              : release of the held frame (pulse)
//   frame_done                 : pulse when image_valid rises
//   busy                       : a frame is being received
//   err_timeout, err_drop,
//   err_checksum               : error pulses
// All outputs are registered and reset to 0.
// -----------------------------------------------------------------------------
module image_loader #(
  parameter int         NUM_PIXELS     = image_loader_pkg::NUM_PIXELS,
  parameter int         ADDR_W         = image_loader_pkg::ADDR_W,
  parameter logic [7:0] SYNC0          = image_loader_pkg::SYNC0,
  parameter logic [7:0] SYNC1          = image_loader_pkg::SYNC1,
  parameter int         TIMEOUT_CYCLES = image_loader_pkg::TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic              ram_wr_en,
  output logic              image_valid,
  input  logic              image_consume,
  output logic              frame_done,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_drop,
  output logic              err_checksum
);

  import image_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(NUM_PIXELS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              wr_en_next;
  logic              timeout_next;
  logic              drop_next;
  logic              active;
  logic              gap_expired;

  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              wr_en_reg;
  logic              image_valid_reg;
  logic              frame_done_reg;
  logic              busy_reg;
  logic              err_timeout_reg;
  logic              err_drop_reg;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [7:0] sum_reg, sum_next;
  logic       cks_next;
  logic       err_checksum_reg;
`endif

  // States in which a frame is in flight and the gap timer is armed.
`ifdef IMAGE_LOADER_CHECKSUM_EN
  assign active = (state_reg == ST_SYNC1) || (state_reg == ST_LOAD) ||
                  (state_reg == ST_CHECK);
`else
  assign active = (state_reg == ST_SYNC1) || (state_reg == ST_LOAD);
`endif

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid || !active),
    .expired(gap_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wr_en_next   = 1'b0;
    timeout_next = 1'b0;
    drop_next    = 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    sum_next     = sum_reg;
    cks_next     = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC0) state_next = ST_SYNC1;
      end
      ST_SYNC1: begin
        if (rx_valid) begin
          if (rx_data == SYNC1) begin
            state_next = ST_LOAD;
            cnt_next   = '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            sum_next   = '0;
`endif
          end else if (rx_data != SYNC0) begin
            // A repeated SYNC0 keeps us waiting for SYNC1.
            state_next = ST_IDLE;
          end
        end else if (gap_expired) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          wr_en_next = 1'b1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
          sum_next   = sum_reg + rx_data;
`endif
          if (cnt_reg == LAST_PIXEL) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
            state_next = ST_CHECK;
`else
            state_next = ST_PEND;
`endif
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (gap_expired) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end
`ifdef IMAGE_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == sum_reg) begin
            state_next = ST_PEND;
          end else begin
            cks_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (gap_expired) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end
`endif
      // One spare cycle so the last RAM write has landed before handoff.
      ST_PEND: state_next = ST_HOLD;
      ST_HOLD: begin
        // Bytes arriving while the image is held are never parsed, even when
        // they coincide with the release.
        if (rx_valid) drop_next = 1'b1;
        if (image_consume) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      wr_en_reg       <= 1'b0;
      image_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_drop_reg    <= 1'b0;
    end else begin
      if (wr_en_next) begin
        wr_addr_reg <= cnt_reg;
        wr_data_reg <= rx_data;
      end
      wr_en_reg       <= wr_en_next;
      image_valid_reg <= (state_next == ST_HOLD);
      frame_done_reg  <= (state_reg == ST_PEND);
      busy_reg        <= active;
      err_timeout_reg <= timeout_next;
      err_drop_reg    <= drop_next;
    end
  end

`ifdef IMAGE_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg          <= '0;
      err_checksum_reg <= 1'b0;
    end else begin
      sum_reg          <= sum_next;
      err_checksum_reg <= cks_next;
    end
  end
  assign err_checksum = err_checksum_reg;
`else
  assign err_checksum = 1'b0;
`endif

  assign ram_wr_addr = wr_addr_reg;
  assign ram_wr_data = wr_data_reg;
  assign ram_wr_en   = wr_en_reg;
  assign image_valid = image_valid_reg;
  assign frame_done  = frame_done_reg;
  assign busy        = busy_reg;
  assign err_timeout = err_timeout_reg;
  assign err_drop    = err_drop_reg;

endmodule

// File: tb/tb_image_loader.sv
// -----------------------------------------------------------------------------
// tb_image_loader
// Directed test of image_loader with a frame-level reference model compared
// against the DUT outputs on every falling edge, plus literal expectations.
// Honours IMAGE_LOADER_CHECKSUM_EN (trailer byte sent when defined).
// -----------------------------------------------------------------------------
module tb_image_loader;

  localparam int TO   = 50;
  localparam int NPIX = 784;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       image_consume;
  logic [9:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_wr_en, image_valid, frame_done, busy;
  logic       err_timeout, err_drop, err_checksum;

  image_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .image_valid(image_valid), .image_consume(image_consume),
    .frame_done(frame_done), .busy(busy), .err_timeout(err_timeout),
    .err_drop(err_drop), .err_checksum(err_checksum)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 waiting for header, 1 header half seen, 2 pixels, 3 trailer,
  // 4 settling, 5 image held.
  typedef struct {
    int phase; int cnt; int sum; int last;
    bit wr_en; int addr; int data; bit valid; bit done;
    bit busy; bit to; bit drop; bit cks;
  } model_t;

  model_t mdl = '{default: 0};
  int     cyc = 0;

  function automatic model_t step(model_t m, int now, bit rv, int rd, bit ic);
    model_t n = m;
    bit     late;
    n.wr_en = 0; n.done = 0; n.to = 0; n.drop = 0; n.cks = 0;
    n.busy  = (m.phase >= 1 && m.phase <= 3);
    // more than TO quiet cycles since the last byte of an open frame
    late = !rv && ((now - m.last) > TO);
    if (rv) n.last = now;
    case (m.phase)
      0: if (rv && rd == 8'hAA) n.phase = 1;
      1: begin
        if (rv) begin
          if (rd == 8'h55) begin n.phase = 2; n.cnt = 0; n.sum = 0; end
          else if (rd != 8'hAA) n.phase = 0;
        end else if (late) begin n.to = 1; n.phase = 0; end
      end
      2: begin
        if (rv) begin
          n.wr_en = 1; n.addr = m.cnt; n.data = rd;
          n.sum = (m.sum + rd) % 256;
          if (m.cnt == NPIX - 1) n.phase = CK ? 3 : 4;
          else n.cnt = m.cnt + 1;
        end else if (late) begin n.to = 1; n.phase = 0; end
      end
      3: begin
        if (rv) begin
          if (rd == m.sum) n.phase = 4;
          else begin n.cks = 1; n.phase = 0; end
        end else if (late) begin n.to = 1; n.phase = 0; end
      end
      4: begin n.phase = 5; n.done = 1; end
      default: begin
        if (rv) n.drop = 1;
        if (ic) n.phase = 0;
      end
    endcase
    n.valid = (n.phase == 5);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= '{default: 0};
    else mdl <= step(mdl, cyc, rx_valid, int'(rx_data), image_consume);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM and event monitor ----------------
  logic [7:0] shadow [NPIX];
  always @(posedge clk) if (ram_wr_en) shadow[ram_wr_addr] <= ram_wr_data;

  int wr_cnt = 0, done_cnt = 0, to_cnt = 0, drop_cnt = 0, cks_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (ram_wr_en)    wr_cnt   <= wr_cnt + 1;
    if (frame_done)   begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (err_timeout)  to_cnt   <= to_cnt + 1;
    if (err_drop)     drop_cnt <= drop_cnt + 1;
    if (err_checksum) cks_cnt  <= cks_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;
  int exp_px [NPIX];
  int last_rx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int px(int seed, int i);
    return (i + seed) % 256;
  endfunction

  function automatic int sum_px(int seed);
    int s = 0;
    for (int i = 0; i < NPIX; i++) s += px(seed, i);
    return s % 256;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b; last_rx = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pixels(input int seed, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      exp_px[i] = px(seed, i);
      send(8'(px(seed, i)));
    end
  endtask

  task automatic send_frame(input int seed, input int cks_delta);
    send(8'hAA); send(8'h55);
    send_pixels(seed, 0, NPIX);
    if (CK) send(8'((sum_px(seed) + cks_delta) % 256));
  endtask

  task automatic readback(input string name);
    int bad = 0;
    for (int i = 0; i < NPIX; i++) if (int'(shadow[i]) != exp_px[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic consume();
    image_consume = 1'b1;
    @(posedge clk); #1;
    image_consume = 1'b0;
  endtask

  int b_wr, b_done, b_to, b_drop, b_cks;
  task automatic snap();
    b_wr = wr_cnt; b_done = done_cnt; b_to = to_cnt; b_drop = drop_cnt; b_cks = cks_cnt;
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; image_consume = 1'b0;

    fork
      forever begin
        @(negedge clk);
        chk("wr_en", ram_wr_en, mdl.wr_en);
        if (mdl.wr_en) begin
          chk("wr_addr", ram_wr_addr, mdl.addr);
          chk("wr_data", ram_wr_data, mdl.data);
        end
        chk("image_valid", image_valid, mdl.valid);
        chk("frame_done", frame_done, mdl.done);
        chk("busy", busy, mdl.busy);
        chk("err_timeout", err_timeout, mdl.to);
        chk("err_drop", err_drop, mdl.drop);
        chk("err_checksum", err_checksum, mdl.cks);
      end
    join_none

    // model pin: sum of (0..783) mod 256
    chk("model_sum_seed0", sum_px(0), 248);

    idle(3);
    chk("reset_outputs", {ram_wr_en, image_valid, frame_done, busy,
                          err_timeout, err_drop, err_checksum}, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: clean back-to-back frame
    snap();
    send_frame(0, 0);
    idle(4);
    chk("t1_writes", wr_cnt - b_wr, 784);
    chk("t1_done_cnt", done_cnt - b_done, 1);
    chk("t1_done_latency", done_cyc - last_rx, 2);
    chk("t1_valid", image_valid, 1);
    readback("t1_ram");
    consume();
    chk("t1_released", image_valid, 0);
    idle(2);

    // 2: leading garbage and repeated SYNC0
    snap();
    send(8'h55); send(8'hAA);
    send_frame(7, 0);
    idle(4);
    chk("t2_writes", wr_cnt - b_wr, 784);
    chk("t2_done_cnt", done_cnt - b_done, 1);
    readback("t2_ram");
    consume();
    idle(2);

    // 3: stall mid-frame -> timeout, then a good frame
    snap();
    send(8'hAA); send(8'h55);
    send_pixels(1, 0, 100);
    idle(TO + 10);
    chk("t3_timeouts", to_cnt - b_to, 1);
    chk("t3_writes", wr_cnt - b_wr, 100);
    chk("t3_valid_low", image_valid, 0);
    chk("t3_no_done", done_cnt - b_done, 0);
    send_frame(3, 0);
    idle(4);
    chk("t3_recover_done", done_cnt - b_done, 1);
    readback("t3_ram");

    // 4: bytes while held are dropped; consume together with SYNC0
    snap();
    send(8'h12); idle(2); send(8'hAA); idle(1); send(8'h55); idle(2);
    chk("t4_drops", drop_cnt - b_drop, 3);
    chk("t4_no_writes", wr_cnt - b_wr, 0);
    chk("t4_still_valid", image_valid, 1);
    rx_valid = 1'b1; rx_data = 8'hAA; image_consume = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; image_consume = 1'b0;
    chk("t4_consume_valid", image_valid, 0);
    send(8'h55);
    idle(2);
    chk("t4_drops_total", drop_cnt - b_drop, 4);
    chk("t4_not_busy", busy, 0);
    chk("t4_still_no_writes", wr_cnt - b_wr, 0);

    // 5: reset at pixel 400, then a fresh frame from address 0
    send(8'hAA); send(8'h55);
    send_pixels(9, 0, 400);
    #3 rst_n = 1'b0;
    #1 chk("t5_async_reset", {ram_wr_en, image_valid, frame_done, busy,
                              err_timeout, err_drop, err_checksum}, 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    snap();
    send(8'hAA); send(8'h55);
    send_pixels(11, 0, 1);
    chk("t5_first_addr", ram_wr_addr, 0);
    chk("t5_first_wr_en", ram_wr_en, 1);
    send_pixels(11, 1, NPIX);
    if (CK) send(8'(sum_px(11)));
    idle(4);
    chk("t5_writes", wr_cnt - b_wr, 784);
    chk("t5_done", done_cnt - b_done, 1);
    readback("t5_ram");
    consume();
    idle(2);

`ifdef IMAGE_LOADER_CHECKSUM_EN
    // 6: bad trailer
    snap();
    send_frame(5, 1);
    idle(4);
    chk("t6_cks_err", cks_cnt - b_cks, 1);
    chk("t6_no_done", done_cnt - b_done, 0);
    chk("t6_valid_low", image_valid, 0);
    send_frame(5, 0);
    idle(4);
    chk("t6_good_done", done_cnt - b_done, 1);
    consume();
    idle(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_loader.md
# image_loader

Frame receiver that writes a 784-byte MNIST image into the inference image RAM. Consumes a byte stream (one byte per `rx_valid` pulse, typically from the UART receiver), detects a two-byte sync header, writes pixel bytes to sequential RAM addresses through the RAM's synchronous write port, and hands the completed image to the inference controller. The image is held stable until the controller releases it.

## Interface
- `NUM_PIXELS`, 784: pixel bytes per frame.
- `ADDR_W`, 10: RAM address width.
- `SYNC0`, 8'hAA: first header byte.
- `SYNC1`, 8'h55: second header byte.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle gap between bytes inside a frame.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `ram_wr_addr` out ADDR_W: RAM write address.
- `ram_wr_data` out 8: RAM write data.
- `ram_wr_en` out 1: RAM write strobe.
- `image_valid` out 1: level; RAM holds a complete frame.
- `image_consume` in 1: one-cycle pulse from the inference controller releasing the image.
- `frame_done` out 1: one-cycle pulse when `image_valid` rises.
- `busy` out 1: frame reception in progress (SYNC1, LOAD or CHECK state).
- `err_timeout` out 1: one-cycle pulse on an inter-byte timeout abort.
- `err_drop` out 1: one-cycle pulse when a byte is discarded in HOLD.
- `err_checksum` out 1: one-cycle pulse on a checksum mismatch. Tied 0 when the checksum is compiled out.

## Operation
- States:
  - IDLE: `rx_valid` with `SYNC0` goes to SYNC1. Other bytes are ignored.
  - SYNC1: `SYNC1` byte goes to LOAD with pixel counter = 0. `SYNC0` byte stays in SYNC1. Any other byte goes to IDLE.
  - LOAD: each byte is written to address = counter, then the counter increments. The byte written at counter = NUM_PIXELS-1 moves to CHECK (checksum enabled) or PEND (disabled).
  - CHECK: the next byte is compared with the running sum. Match goes to PEND. Mismatch pulses `err_checksum` and goes to IDLE.
  - PEND: one cycle, then HOLD. This gives the final RAM write time to land.
  - HOLD: `image_valid` = 1. `image_consume` goes to IDLE. Every `rx_valid` pulses `err_drop`, and the byte is not written or parsed.
- Timeout:
  - Gap counter clears on every `rx_valid`, and in IDLE and HOLD.
  - In SYNC1, LOAD and CHECK, reaching TIMEOUT_CYCLES pulses `err_timeout` and goes to IDLE. The counter clears.
  - RAM keeps the partial data; `image_valid` stays 0.
- `image_consume` outside HOLD is ignored.
- `rx_valid` together with `image_consume` in HOLD: `err_drop` pulses, the state goes to IDLE, and the byte is not treated as `SYNC0`.
- Pixel counter is ADDR_W bits and never exceeds NUM_PIXELS-1. There is no wrap-around; the frame ends at NUM_PIXELS.
- Reset, including mid-frame:
  - State goes to IDLE; counters and all outputs go to 0.
  - RAM contents are not cleared.

## Timing
- All outputs are registered. Every output resets to 0.
- `rx_valid` at cycle N in LOAD gives `ram_wr_en`=1 at N+1, with `ram_wr_addr`/`ram_wr_data` holding that byte. The write lands at the end of N+1.
- Last pixel at cycle N, checksum disabled: PEND at N+1; `image_valid` rises and `frame_done` pulses at N+2.
- Checksum byte at cycle M: `frame_done`/`image_valid` at M+2 on a match, or `err_checksum` at M+1 on a mismatch.
- `image_consume` at cycle K: `image_valid` = 0 at K+1.
- `busy` follows state with a 1-cycle register delay.
- Maximum sustained input rate is 1 byte per cycle, with no loss in LOAD.

## Configuration
- `IMAGE_LOADER_CHECKSUM_EN`
  - Defined: an 8-bit modulo-256 sum of the pixel bytes is accumulated in LOAD, and the CHECK state is present. The frame is 2+784+1 bytes.
  - Undefined: no CHECK state and no accumulator; `err_checksum` is tied 0. The frame is 2+784 bytes.

## Structure
- `image_loader_pkg`: state enum, `SYNC0`/`SYNC1` defaults, `NUM_PIXELS`, `ADDR_W`.
- Sub-module `byte_gap_timer`: clearable saturating counter with an `expired` output, sized by $clog2(TIMEOUT_CYCLES+1).

## Test plan
- AA 55 then bytes 0..783 mod 256, back-to-back → 784 writes, addr 0..783 with data = addr mod 256; `frame_done` 2 cycles after the last write; RAM readback matches.
- 55 AA AA 55 + frame → the leading garbage is ignored, the repeated AA stays in SYNC1, and the frame loads correctly.
- AA 55 + 100 bytes, then silence → `err_timeout` after TIMEOUT_CYCLES (use 50 in the bench); `image_valid` stays 0; a following full frame loads.
- Frame complete, then 3 bytes before `image_consume` → 3 `err_drop` pulses, no writes; consume together with `rx_valid`=AA → IDLE with the byte dropped.
- `rst_n` low at pixel 400 → all outputs 0 asynchronously; the next full frame loads from addr 0.
- CHECKSUM_EN: correct trailer → `frame_done`; trailer+1 → `err_checksum`, `image_valid` stays 0.
